// File: rtl/mem_pkg.sv
// ============================================================================
//  Module   : mem_pkg
//  Purpose  : Shared widths and enums for the line-memory arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam int ADDR_W = 26;
  localparam int LINE_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } mem_owner_t;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Round-robin icache/dcache line arbiter in front of a fixed
//             LATENCY-cycle line memory; one request in flight at a time.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = mem_pkg::ADDR_W,
  parameter int LINE_W  = mem_pkg::LINE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ready,
  output logic [LINE_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_ready,
  output logic [LINE_W-1:0] dc_rdata,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [LINE_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [LINE_W-1:0] mem_rdata
);

  import mem_pkg::*;

  localparam int               c_CNT_W    = $clog2(LATENCY + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  mem_state_t          r_state;
  mem_owner_t          r_owner;
  mem_owner_t          r_last_grant;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   r_wdata;
  logic                r_mem_we;
  logic                r_ic_ready;
  logic                r_dc_ready;
  logic [LINE_W-1:0]   r_ic_rdata;
  logic [LINE_W-1:0]   r_dc_rdata;

  logic                w_any_req;
  logic                w_grant_dc;
  mem_owner_t          w_grant_owner;
  logic                w_req_we;
  logic [ADDR_W-1:0]   w_req_addr;
  logic [LINE_W-1:0]   w_req_wdata;

  // On a tie the port that did not win last time is granted.
  assign w_any_req     = ic_req | dc_req;
  assign w_grant_dc    = dc_req & (~ic_req | (r_last_grant == OWN_IC));
  assign w_grant_owner = w_grant_dc ? OWN_DC : OWN_IC;
  assign w_req_we      = w_grant_dc & dc_we;
  assign w_req_addr    = w_grant_dc ? dc_addr : ic_addr;
  assign w_req_wdata   = w_grant_dc ? dc_wdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_owner      <= OWN_IC;
      r_last_grant <= OWN_IC;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_mem_we     <= 1'b0;
      r_ic_ready   <= 1'b0;
      r_dc_ready   <= 1'b0;
      r_ic_rdata   <= '0;
      r_dc_rdata   <= '0;
    end else begin
      r_mem_we   <= 1'b0;
      r_ic_ready <= 1'b0;
      r_dc_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_owner      <= w_grant_owner;
            r_last_grant <= w_grant_owner;
            r_we         <= w_req_we;
            r_addr       <= w_req_addr;
            r_wdata      <= w_req_wdata;
            r_cnt        <= c_CNT_LOAD;
            // Write enable is registered, so it is raised one edge ahead of the cnt==0 cycle.
            r_mem_we     <= w_req_we & (c_CNT_LOAD == '0);
            r_state      <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt == '0) begin
            if (!r_we) begin
              if (r_owner == OWN_DC) r_dc_rdata <= mem_rdata;
              else                   r_ic_rdata <= mem_rdata;
            end
            if (r_owner == OWN_DC) r_dc_ready <= 1'b1;
            else                   r_ic_ready <= 1'b1;
            r_state <= RESP;
          end else begin
            r_cnt    <= r_cnt - 1'b1;
            r_mem_we <= r_we & (r_cnt == c_CNT_ONE);
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ic_ready  = r_ic_ready;
  assign ic_rdata  = r_ic_rdata;
  assign dc_ready  = r_dc_ready;
  assign dc_rdata  = r_dc_rdata;
  assign mem_raddr = r_addr;
  assign mem_waddr = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_we    = r_mem_we;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed and random line requests against a
// request-level model of arbitration order, latency and memory contents.
`timescale 1ns/1ps
`default_nettype none

module tb_mem_arbiter;

  localparam int L  = 4;
  localparam int AW = 26;
  localparam int LW = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic          ic_req, dc_req, dc_we;
  logic [AW-1:0] ic_addr, dc_addr;
  logic [LW-1:0] dc_wdata;
  logic          ic_ready, dc_ready, mem_we;
  logic [LW-1:0] ic_rdata, dc_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_raddr, mem_waddr;

  logic          ld_en;
  logic [3:0]    ld_addr;
  logic [LW-1:0] ld_data;
  logic [LW-1:0] ram [0:15];

  assign mem_rdata = ram[mem_raddr[3:0]];
  always @(posedge clk) begin
    if (ld_en)       ram[ld_addr]        <= ld_data;
    else if (mem_we) ram[mem_waddr[3:0]] <= mem_wdata;
  end

  mem_arbiter #(.LATENCY(L), .ADDR_W(AW), .LINE_W(LW)) u_dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ready(ic_ready), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ready(dc_ready), .dc_rdata(dc_rdata),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  // Second instance exercises the single-cycle access corner.
  logic          ic_req1, dc_req1;
  logic [AW-1:0] ic_addr1, dc_addr1;
  logic          ic_ready1, dc_ready1, mem_we1;
  logic [LW-1:0] ic_rdata1, dc_rdata1, mem_wdata1, mem_rdata1;
  logic [AW-1:0] mem_raddr1, mem_waddr1;

  assign mem_rdata1 = {4{6'd0, mem_raddr1}};

  mem_arbiter #(.LATENCY(1), .ADDR_W(AW), .LINE_W(LW)) u_dut1 (
    .clk(clk), .reset(reset),
    .ic_req(ic_req1), .ic_addr(ic_addr1), .ic_ready(ic_ready1), .ic_rdata(ic_rdata1),
    .dc_req(dc_req1), .dc_we(1'b0), .dc_addr(dc_addr1), .dc_wdata({LW{1'b0}}),
    .dc_ready(dc_ready1), .dc_rdata(dc_rdata1),
    .mem_raddr(mem_raddr1), .mem_waddr(mem_waddr1), .mem_wdata(mem_wdata1),
    .mem_we(mem_we1), .mem_rdata(mem_rdata1)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [LW-1:0] ref_mem [0:15];
  logic [LW-1:0] ref_ic_rdata, ref_dc_rdata;
  bit            last_dc;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    last_dc      = 1'b0;
    ref_ic_rdata = '0;
    ref_dc_rdata = '0;
  endtask

  // One request from either or both ports; model decides order, timing and data.
  task automatic run_pair(input bit ic_on, input bit dc_on, input bit we,
                          input logic [3:0] ia, input logic [3:0] da,
                          input logic [LW-1:0] wd);
    bit            first_dc, raddr_ok;
    int            exp_ic_cyc, exp_dc_cyc, exp_we_cyc;
    int            ic_cyc, dc_cyc, we_cyc, n_ic, n_dc, n_we;
    logic [LW-1:0] exp_ic, exp_dc, ic_got, dc_got, wdat_got;
    logic [AW-1:0] wadr_got, a_first, a_second;

    first_dc = dc_on && (!ic_on || !last_dc);
    exp_ic = ref_ic_rdata;
    exp_dc = ref_dc_rdata;
    if (first_dc) begin
      if (!we) exp_dc = ref_mem[da]; else ref_mem[da] = wd;
      if (ic_on) exp_ic = ref_mem[ia];
    end else begin
      if (ic_on) exp_ic = ref_mem[ia];
      if (dc_on) begin
        if (!we) exp_dc = ref_mem[da]; else ref_mem[da] = wd;
      end
    end
    exp_ic_cyc = !ic_on ? 0 : (first_dc ? 2*L+3 : L+1);
    exp_dc_cyc = !dc_on ? 0 : (first_dc ? L+1 : 2*L+3);
    exp_we_cyc = (dc_on && we) ? exp_dc_cyc - 1 : 0;
    a_first    = first_dc ? AW'(da) : AW'(ia);
    a_second   = first_dc ? AW'(ia) : AW'(da);

    ic_cyc = 0; dc_cyc = 0; we_cyc = 0; n_ic = 0; n_dc = 0; n_we = 0;
    ic_got = '0; dc_got = '0; wdat_got = '0; wadr_got = '0; raddr_ok = 1'b1;

    @(negedge clk);
    ic_req = ic_on; ic_addr = AW'(ia);
    dc_req = dc_on; dc_we = we; dc_addr = AW'(da); dc_wdata = wd;
    for (int k = 1; k <= 2*L+6; k++) begin
      @(negedge clk);
      if (k <= L && mem_raddr !== a_first) raddr_ok = 1'b0;
      if (ic_on && dc_on && k >= L+3 && k <= 2*L+2 && mem_raddr !== a_second) raddr_ok = 1'b0;
      if (ic_ready) begin n_ic++; ic_cyc = k; ic_got = ic_rdata; ic_req = 1'b0; end
      if (dc_ready) begin n_dc++; dc_cyc = k; dc_got = dc_rdata; dc_req = 1'b0; end
      if (mem_we)   begin n_we++; we_cyc = k; wadr_got = mem_waddr; wdat_got = mem_wdata; end
    end
    ic_req = 1'b0; dc_req = 1'b0;

    chk("ic_ready_cycle", ic_cyc, exp_ic_cyc);
    chk("dc_ready_cycle", dc_cyc, exp_dc_cyc);
    chk("ic_ready_pulses", n_ic, ic_on ? 1 : 0);
    chk("dc_ready_pulses", n_dc, dc_on ? 1 : 0);
    chk("mem_we_pulses", n_we, (dc_on && we) ? 1 : 0);
    chk("mem_raddr_busy", raddr_ok, 1'b1);
    if (ic_on) chk("ic_rdata", ic_got, exp_ic);
    if (dc_on) chk("dc_rdata", dc_got, exp_dc);
    if (dc_on && we) begin
      chk("mem_we_cycle", we_cyc, exp_we_cyc);
      chk("mem_waddr", wadr_got, AW'(da));
      chk("mem_wdata", wdat_got, wd);
    end

    if (ic_on) ref_ic_rdata = exp_ic;
    if (dc_on) ref_dc_rdata = exp_dc;
    last_dc = (ic_on && dc_on) ? !first_dc : dc_on;
  endtask

  initial begin
    bit            r_ic, r_dc, r_we, seen;
    int            np;
    logic [LW-1:0] rd;

    reset = 1'b1;
    ic_req = 0; dc_req = 0; dc_we = 0; ic_addr = '0; dc_addr = '0; dc_wdata = '0;
    ic_req1 = 0; dc_req1 = 0; ic_addr1 = AW'(3); dc_addr1 = AW'(9);
    ld_en = 0; ld_addr = '0; ld_data = '0;

    for (int i = 0; i < 16; i++) begin
      rd = (i == 0) ? 128'h0800_0E0A_0018_A518_0003_3002_0800_020A
                    : {$urandom, $urandom, $urandom, $urandom};
      ref_mem[i] = rd;
      @(negedge clk);
      ld_en = 1'b1; ld_addr = 4'(i); ld_data = rd;
    end
    @(negedge clk);
    ld_en = 1'b0;
    model_reset();

    ic_req = 1'b1; dc_req = 1'b1; dc_we = 1'b1; dc_addr = AW'(1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready_we", {ic_ready, dc_ready, mem_we}, 3'b000);
    end
    chk("rst_ic_rdata", ic_rdata, '0);
    chk("rst_dc_rdata", dc_rdata, '0);
    chk("rst_addrs", {mem_raddr, mem_waddr}, '0);
    chk("rst_wdata", mem_wdata, '0);
    ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", {ic_ready, dc_ready, mem_we}, 3'b000);

    run_pair(1, 0, 0, 4'd0, 4'd0, '0);
    run_pair(0, 1, 1, 4'd0, 4'd5, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0);
    run_pair(1, 0, 0, 4'd5, 4'd0, '0);
    run_pair(1, 1, 0, 4'd2, 4'd3, '0);
    run_pair(1, 1, 0, 4'd4, 4'd6, '0);

    for (int i = 0; i < 20; i++) begin
      r_ic = 1'($urandom);
      r_dc = 1'($urandom);
      r_we = 1'($urandom);
      if (!r_ic && !r_dc) r_ic = 1'b1;
      run_pair(r_ic, r_dc, r_we, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               {$urandom, $urandom, $urandom, $urandom});
    end

    // Write to line 7 dropped by a reset in its second BUSY cycle.
    @(negedge clk);
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = AW'(7);
    dc_wdata = ~ref_mem[7];
    repeat (2) @(negedge clk);
    reset = 1'b1; dc_req = 1'b0; dc_we = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 1) reset = 1'b0;
      if (mem_we || dc_ready || ic_ready) seen = 1'b1;
    end
    model_reset();
    chk("mid_rst_no_activity", seen, 1'b0);
    chk("mid_rst_dc_rdata", dc_rdata, '0);
    run_pair(1, 0, 0, 4'd7, 4'd0, '0);

    // LATENCY=1: both ports held high, owners must alternate every 3 cycles.
    np = 0;
    @(negedge clk);
    ic_req1 = 1'b1; dc_req1 = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (ic_ready1 || dc_ready1) begin
        chk("l1_pulse_cycle", k, 2 + 3*np);
        chk("l1_owner", {ic_ready1, dc_ready1}, (np % 2 == 0) ? 2'b01 : 2'b10);
        if (dc_ready1) chk("l1_dc_rdata", dc_rdata1, {4{32'd9}});
        else           chk("l1_ic_rdata", ic_rdata1, {4{32'd3}});
        np++;
      end
      if (mem_we1) chk("l1_no_mem_we", mem_we1, 1'b0);
    end
    ic_req1 = 1'b0; dc_req1 = 1'b0;
    chk("l1_pulse_count", np, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port line-request arbiter between the instruction cache and data cache refill/write-back ports and the main line memory (`ram_memory`). It accepts one 128-bit line request at a time, round-robin when both caches request together. It drives the memory's read address, write address, write data and write-enable, and models a fixed `LATENCY`-cycle memory access. It returns read data and a one-cycle `ready` pulse to the winning requester.

## Interface
- `LATENCY`, 4, memory access cycles per request; legal range ≥1
- `ADDR_W`, 26, line address width; matches memory line address
- `LINE_W`, 128, line width; four 32-bit words, word 0 in bits [31:0]

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `ic_req`  in  1  icache read request, held until `ic_ready`
- `ic_addr`  in  ADDR_W  icache line address
- `ic_ready`  out  1  one-cycle pulse; `ic_rdata` valid this cycle
- `ic_rdata`  out  LINE_W  line read for icache
- `dc_req`  in  1  dcache request, held until `dc_ready`
- `dc_we`  in  1  1 = line write-back, 0 = line read
- `dc_addr`  in  ADDR_W  dcache line address
- `dc_wdata`  in  LINE_W  write-back data
- `dc_ready`  out  1  one-cycle pulse; completes the request (read data valid if `dc_we`=0)
- `dc_rdata`  out  LINE_W  line read for dcache
- `mem_raddr`  out  ADDR_W  memory read line address
- `mem_waddr`  out  ADDR_W  memory write line address
- `mem_wdata`  out  LINE_W  memory write data
- `mem_we`  out  1  memory write enable
- `mem_rdata`  in  LINE_W  memory read data, combinational from `mem_raddr`

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: request sampled at clock edge.
  - One requester active → grant it.
  - Both active → grant the one not granted last; `last_grant` resets to IC, so first tie goes to DC.
  - On grant: latch addr/we/wdata and owner. Load `cnt` = LATENCY-1. Go to BUSY.
  - `last_grant` updates on every grant.
- BUSY:
  - `mem_raddr`/`mem_waddr` = latched addr; `mem_wdata` = latched data.
  - `cnt` decrements each cycle.
  - At `cnt`==0:
    - read: capture `mem_rdata` into the owner's rdata register.
    - write: `mem_we`=1 for exactly this cycle.
  - Then go to RESP.
- RESP: owner's `ready`=1 for one cycle. Return to IDLE; no request is sampled in RESP.
- Holding `req` high in the IDLE cycle after `ready` is a new request.
- icache requests are always reads.
- `ic_rdata`/`dc_rdata` hold their last captured value until overwritten by a new read for that port.
- A write does not modify `dc_rdata`.
- Reset, including mid-BUSY/RESP:
  - State → IDLE, `cnt`→0, `last_grant`→IC.
  - All outputs → 0 (`ready`s, `mem_we`, addresses, data registers).
  - An in-flight request is dropped: no `ready`, no `mem_we`, so a pending write is lost.
  - Requesters must re-issue after reset.

## Timing
- Request sampled in IDLE at edge 0 → BUSY for cycles 1..LATENCY → RESP (`ready`) in cycle LATENCY+1 → IDLE in LATENCY+2.
- Request-to-ready latency: LATENCY+1 cycles; throughput: one request per LATENCY+2 cycles.
- `mem_we` is high only in cycle LATENCY, never in IDLE/RESP.
- `mem_raddr` is stable from cycle 1 through LATENCY, so combinational memory read data is settled at capture.
- LATENCY=1: a single BUSY cycle is both capture and write cycle.
- Non-granted requester keeps `req` asserted and waits; it is granted in the first IDLE cycle after the current RESP.

## Structure
- Shared package `mem_pkg`:
  - `ADDR_W`, `LINE_W` constants
  - `mem_state_t` enum {IDLE, BUSY, RESP}
  - `mem_owner_t` enum {OWN_IC, OWN_DC}
- Single module, no sub-module. Arbitration, counter and FSM live inline; the counter is `$clog2(LATENCY+1)` bits wide.

## Test plan
- Reset asserted 3 cycles → all outputs 0, state IDLE; `dc_req`/`ic_req` high during reset produce no grant.
- LATENCY=4, memory line 0 = {w3,w2,w1,w0} = {32'h0800_0E0A, 32'h0018_A518, 32'h0003_3002, 32'h0800_020A}; `ic_req` addr 0 at edge 0 → `mem_raddr`=0 cycles 1-4, `ic_ready` pulse cycle 5 with `ic_rdata` = that line, `dc_ready` stays 0.
- `dc_req` we=1 addr 5 data 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0 → `mem_we`=1 only in cycle 4 with `mem_waddr`=5; `dc_ready` cycle 5; then `ic_req` addr 5 returns the same 128-bit value.
- `ic_req` and `dc_req` both high at edge 0 → `dc_ready` cycle 5; ic granted edge 6, `ic_ready` cycle 11; a second simultaneous pair is granted to DC first.
- Reset asserted in cycle 2 of a dcache write to addr 7 → `mem_we` never asserts, no `dc_ready`, line 7 unchanged on subsequent read.
- LATENCY=1, alternating ic/dc reads held continuously → `ready` pulses every 3 cycles, strictly alternating owners.
